// File: rtl/vga_sync_rx.sv
// Receive-side VGA timing recovery: rebuilds hc/vc from incoming active-low syncs,
// checks them against the configured mode and reports lock, coordinates and errors.
module vga_sync_rx #(
  parameter int activeHvideo = 640,
  parameter int activeVvideo = 480,
  parameter int hfp          = 24,
  parameter int hpulse       = 40,
  parameter int hbp          = 128,
  parameter int vfp          = 9,
  parameter int vpulse       = 3,
  parameter int vbp          = 28,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] x_px,
  output logic [9:0] y_px,
  output logic       activevideo,
  output logic       locked,
  output logic       frame_start,
  output logic       sync_err
);

  localparam int blackH  = hfp + hpulse + hbp;
  localparam int blackV  = vfp + vpulse + vbp;
  localparam int hpixels = activeHvideo + blackH;
  localparam int vlines  = activeVvideo + blackV;

  localparam logic [9:0]  HFP_C    = 10'(hfp);
  localparam logic [9:0]  VFP_C    = 10'(vfp);
  localparam logic [9:0]  HMAX     = 10'(hpixels - 1);
  localparam logic [9:0]  VMAX     = 10'(vlines - 1);
  localparam logic [9:0]  BLACKH_C = 10'(blackH);
  localparam logic [9:0]  BLACKV_C = 10'(blackV);
  localparam logic [10:0] HTO_LAST = 11'(2 * hpixels - 1);
  localparam logic [10:0] VTO_LAST = 11'(2 * vlines - 1);
  localparam logic [2:0]  LOCK_N   = 3'(LOCK_FRAMES);

  logic       hs_meta, hs_s, hs_d;
  logic       vs_meta, vs_s, vs_d;
  logic [9:0] hc, vc, hc_nxt, vc_nxt;
  logic [10:0] h_to, v_to, h_to_nxt, v_to_nxt;
  logic [2:0] good_cnt, good_nxt;
  logic       fall_h, fall_v, h_wrap;
  logic       err_h, err_v, err_ht, err_vt, err_any;

  // Synchronizer + one delay stage; flops idle high like an undriven sync
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_meta <= 1'b1;
      hs_s    <= 1'b1;
      hs_d    <= 1'b1;
      vs_meta <= 1'b1;
      vs_s    <= 1'b1;
      vs_d    <= 1'b1;
    end else begin
      hs_meta <= hsync_in;
      hs_s    <= hs_meta;
      hs_d    <= hs_s;
      vs_meta <= vsync_in;
      vs_s    <= vs_meta;
      vs_d    <= vs_s;
    end
  end

  assign fall_h = hs_d & ~hs_s;
  assign fall_v = vs_d & ~vs_s;
  assign h_wrap = ~fall_h & (hc == HMAX);

  // Timeouts fire on the cycle the counter would reach twice the nominal period
  assign err_h   = fall_h & (hc != HFP_C);
  assign err_v   = fall_v & ((vc != VFP_C) | (hc != 10'd0));
  assign err_ht  = ~fall_h & (h_to == HTO_LAST);
  assign err_vt  = ~fall_v & h_wrap & (v_to == VTO_LAST);
  assign err_any = err_h | err_v | err_ht | err_vt;

  always_comb begin
    hc_nxt   = hc + 10'd1;
    vc_nxt   = vc;
    h_to_nxt = h_to + 11'd1;
    v_to_nxt = v_to;
    good_nxt = good_cnt;

    if (fall_h) begin
      hc_nxt   = HFP_C + 10'd1;
      h_to_nxt = '0;
    end else if (hc == HMAX) begin
      hc_nxt = '0;
    end

    if (fall_v) begin
      vc_nxt   = VFP_C;
      v_to_nxt = '0;
    end else if (h_wrap) begin
      vc_nxt   = (vc == VMAX) ? 10'd0 : vc + 10'd1;
      v_to_nxt = v_to + 11'd1;
    end

    // An error in the same cycle as a good-looking fall_v wins
    if (err_any) begin
      good_nxt = '0;
    end else if (fall_v && (good_cnt != 3'd7)) begin
      good_nxt = good_cnt + 3'd1;
    end
  end

  // Counter / lock state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc       <= '0;
      vc       <= '0;
      h_to     <= '0;
      v_to     <= '0;
      good_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      hc       <= hc_nxt;
      vc       <= vc_nxt;
      h_to     <= h_to_nxt;
      v_to     <= v_to_nxt;
      good_cnt <= good_nxt;
      locked   <= (good_nxt >= LOCK_N);
    end
  end

  assign activevideo = locked & (hc >= BLACKH_C) & (vc >= BLACKV_C);
  assign x_px        = activevideo ? (hc - BLACKH_C) : 10'd0;
  assign y_px        = activevideo ? (vc - BLACKV_C) : 10'd0;
  assign frame_start = activevideo & (hc == BLACKH_C) & (vc == BLACKV_C);
  assign sync_err    = err_any;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Scoreboard bench for vga_sync_rx using a reduced video mode (25x12 total) so
// several complete frames, lock/loss and timeout scenarios fit in a short run.
`timescale 1ns/1ps
module tb_vga_sync_rx;

  localparam int AH = 16, AV = 6;
  localparam int HFP = 2, HPUL = 3, HBP = 4;
  localparam int VFP = 1, VPUL = 2, VBP = 3;
  localparam int LOCKF = 2;
  localparam int BH = HFP + HPUL + HBP;   // 9
  localparam int BV = VFP + VPUL + VBP;   // 6
  localparam int HPIX = AH + BH;          // 25
  localparam int VLIN = AV + BV;          // 12
  localparam int FRAME = HPIX * VLIN;     // 300

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hsync_in = 1'b1;
  logic       vsync_in = 1'b1;
  logic [9:0] x_px, y_px;
  logic       activevideo, locked, frame_start, sync_err;

  vga_sync_rx #(
    .activeHvideo(AH), .activeVvideo(AV),
    .hfp(HFP), .hpulse(HPUL), .hbp(HBP),
    .vfp(VFP), .vpulse(VPUL), .vbp(VBP),
    .LOCK_FRAMES(LOCKF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .x_px(x_px), .y_px(y_px), .activevideo(activevideo), .locked(locked),
    .frame_start(frame_start), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic       lk;
    logic       act;
    logic       fs;
    logic       err;
    logic       err_care;
    logic [9:0] x;
    logic [9:0] y;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  // Generator state (position of the sample currently on the pins)
  int gh, gv, gline, pin_n;
  bit prev_hs, prev_vs;
  int shift_line = -100;
  int hkill_from = -100;
  int vkill_from = -100, vkill_to = -200;
  int last_hfall = -1000, last_vfall_line = -1000;
  bit acq, exp_lk;
  int gfv;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got === req) passed++;
    else $display("FAIL %s cycle %0d: got %h, required %h", name, cyc, got, req);
  endtask

  // Monitor: one expected record per cycle, aligned two cycles after the pins
  always @(negedge clk) begin
    exp_t e;
    logic [23:0] got, req;
    if (mon_en) begin
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        if (e.due == cyc) begin
          got = {locked, activevideo, frame_start, sync_err & e.err_care, x_px, y_px};
          req = {e.lk, e.act, e.fs, e.err & e.err_care, e.x, e.y};
          check("out{lk,act,fs,err,x,y}", 32'(got), 32'(req));
        end
      end
    end
  end

  task automatic step();
    bit   hs, vs, hf, vf, err, care;
    exp_t e;
    @(negedge clk);
    hs = !(gh >= HFP && gh < HFP + HPUL);
    if (gline == shift_line) hs = !(gh >= HFP + 1 && gh < HFP + HPUL + 1);
    if (gline >= hkill_from && gline <= hkill_from + 1) hs = 1'b1;
    vs = !(gv >= VFP && gv < VFP + VPUL);
    if (gline >= vkill_from && gline <= vkill_to) vs = 1'b1;
    hsync_in = hs;
    vsync_in = vs;
    hf = prev_hs & ~hs;
    vf = prev_vs & ~vs;
    care = 1'b1;
    err  = 1'b0;
    if (acq) begin
      // Counters are unaligned until the first vsync edge, which must mismatch
      care = vf;
      err  = vf;
      if (vf) acq = 1'b0;
    end else begin
      // A late pulse leaves the receiver one pixel behind, so the next pulse mismatches too
      if (hf && (gh != HFP || gline == shift_line + 1)) err = 1'b1;
      if (!hf && pin_n == last_hfall + 2 * HPIX) err = 1'b1;
      if (!vf && gh == HPIX - 1 && gline == last_vfall_line + 2 * VLIN - 1) err = 1'b1;
    end
    e.due      = cyc + 2;
    e.lk       = exp_lk;
    e.act      = exp_lk && gh >= BH && gv >= BV;
    e.x        = e.act ? 10'(gh - BH) : 10'd0;
    e.y        = e.act ? 10'(gv - BV) : 10'd0;
    e.fs       = e.act && gh == BH && gv == BV;
    e.err      = err;
    e.err_care = care;
    if (mon_en) q.push_back(e);
    if (err) begin
      exp_lk = 1'b0;
      gfv    = 0;
    end else if (vf) begin
      gfv++;
      if (gfv >= LOCKF) exp_lk = 1'b1;
    end
    if (hf) last_hfall = pin_n;
    if (vf) last_vfall_line = gline;
    prev_hs = hs;
    prev_vs = vs;
    pin_n++;
    if (gh == HPIX - 1) begin
      gh = 0;
      gline++;
      gv = (gv == VLIN - 1) ? 0 : gv + 1;
    end else begin
      gh++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to(input int h, input int v);
    for (int i = 0; i < 2 * FRAME && !(gh == h && gv == v); i++) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with toggling syncs
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      hsync_in = 1'($urandom_range(0, 1));
      vsync_in = 1'($urandom_range(0, 1));
      #1;
      check("reset_outs", 32'({locked, activevideo, frame_start, sync_err, x_px, y_px}), 32'd0);
    end

    // Cold start mid-frame
    @(negedge clk);
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    gh = 15; gv = 8; gline = 0; pin_n = 0;
    prev_hs = 1'b1; prev_vs = 1'b1;
    acq = 1'b1; exp_lk = 1'b0; gfv = 0;
    mon_en = 1'b1;
    rst_n = 1'b1;
    run(4 * FRAME);

    // Single hsync pulse one pixel late
    run_to(0, 5);
    shift_line = gline;
    run(4 * FRAME);

    // hsync held high for two lines (timeout at twice the line period)
    run_to(0, 4);
    hkill_from = gline;
    run(4 * FRAME);

    // Asynchronous reset in the middle of an active line
    run_to(16, 8);
    @(posedge clk);
    #2;
    check("pre_rst_x", 32'(x_px), 32'd5);
    check("pre_rst_y", 32'(y_px), 32'd2);
    check("pre_rst_locked", 32'(locked), 32'd1);
    mon_en = 1'b0;
    q.delete();
    rst_n = 1'b0;
    #1;
    check("async_rst_outs", 32'({locked, activevideo, frame_start, sync_err, x_px, y_px}), 32'd0);
    run(2);
    rst_n = 1'b1;
    acq = 1'b1; exp_lk = 1'b0; gfv = 0;
    mon_en = 1'b1;
    run(4 * FRAME);

    // vsync pulses dropped for three frames
    run_to(0, 5);
    vkill_from = gline;
    vkill_to   = gline + 3 * VLIN - 1;
    run(6 * FRAME);

    check("final_locked", 32'(locked), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
